serial_add_ctrl: RTL

//  Bit-serial adder controller: sequences a single 1-bit full adder (fa_vr)

---
 rtl/serial_add_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller driving one full-adder cell
`timescale 1ns/1ps

module fa_vr (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             fa_s, fa_co;

    fa_vr u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        c_out_d  = c_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    sum_sh_d = '0;
                    carry_d  = c_in;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // LSB-first: each new sum bit enters at the MSB so the word lines up after WIDTH shifts
                a_sh_d              = a_sh_q >> 1;
                b_sh_d              = b_sh_q >> 1;
                sum_sh_d            = sum_sh_q >> 1;
                sum_sh_d[WIDTH-1]   = fa_s;
                carry_d             = fa_co;
                cnt_d               = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    sum_d   = sum_sh_d;
                    c_out_d = fa_co;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            c_out_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            c_out_q  <= c_out_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign c_out = c_out_q;
endmodule
